// File: rtl/full_add_pkg.sv
// Shared arithmetic constants for the full adder primitive.
package full_add_pkg;

  // Default operand width: the classic single-bit full adder cell.
  localparam int FULL_ADD_WIDTH_DEFAULT = 1;

endpackage

// File: rtl/full_add_cell.sv
// Single-bit full adder cell: pure gates, no state.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic w_prop;

  assign w_prop = a ^ b;
  assign s      = w_prop ^ c_in;
  assign c_out  = (a & b) | (c_in & w_prop);

endmodule

// File: rtl/full_add.sv
// Ripple-carry adder built from chained 1-bit cells.
// The module has two output paths. The combinational outputs depend only on
// a, b and c_in. The registered outputs are for pipelined consumers and are
// cleared asynchronously by rst.
// WIDTH must be at least 1.
module full_add
  import full_add_pkg::*;
#(
  parameter int WIDTH = FULL_ADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out,
  output logic             ovf,
  output logic [WIDTH-1:0] s_reg,
  output logic             c_reg,
  output logic             ovf_reg
);

  // w_carry[i] is the carry into bit i.
  // w_carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_ovf;

  assign w_carry[0] = c_in;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_add_cell u_cell (
      .a     (a[gi]),
      .b     (b[gi]),
      .c_in  (w_carry[gi]),
      .s     (w_sum[gi]),
      .c_out (w_carry[gi+1])
    );
  end

  // Overflow occurs when the carry into the MSB differs from the carry out
  // of the MSB. For WIDTH=1, the carry into the MSB is c_in itself.
  assign s_out = w_sum;
  assign c_out = w_carry[WIDTH];
  assign ovf   = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  // Capture the combinational results. An asserted reset clears them at
  // once, which discards any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s   <= '0;
      r_c   <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_s   <= w_sum;
      r_c   <= w_carry[WIDTH];
      r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
    end
  end

  assign s_reg   = r_s;
  assign c_reg   = r_c;
  assign ovf_reg = r_ovf;

endmodule

// File: tb/tb_full_add.sv
// Directed and randomized checks of full_add at widths 1, 4 and 8.
module tb_full_add;

  logic clk;
  logic rst;

  logic       a1, b1, cin1;
  logic [3:0] a4, b4;
  logic       cin4;
  logic [7:0] a8, b8;
  logic       cin8;

  logic       s_out1, c_out1, ovf1, s_reg1, c_reg1, ovf_reg1;
  logic [3:0] s_out4, s_reg4;
  logic       c_out4, ovf4, c_reg4, ovf_reg4;
  logic [7:0] s_out8, s_reg8;
  logic       c_out8, ovf8, c_reg8, ovf_reg8;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected registered values, one set per width: {ovf, c, s}.
  logic [9:0] e_reg1, e_reg4, e_reg8;

  full_add #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .c_in(cin1), .a(a1), .b(b1),
    .s_out(s_out1), .c_out(c_out1), .ovf(ovf1),
    .s_reg(s_reg1), .c_reg(c_reg1), .ovf_reg(ovf_reg1)
  );

  full_add #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .c_in(cin4), .a(a4), .b(b4),
    .s_out(s_out4), .c_out(c_out4), .ovf(ovf4),
    .s_reg(s_reg4), .c_reg(c_reg4), .ovf_reg(ovf_reg4)
  );

  full_add #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .c_in(cin8), .a(a8), .b(b8),
    .s_out(s_out8), .c_out(c_out8), .ovf(ovf8),
    .s_reg(s_reg8), .c_reg(c_reg8), .ovf_reg(ovf_reg8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. It uses integer addition, takes the sum and carry from
  // the integer result, and detects signed overflow from the operand and
  // result sign bits. The return value is {ovf, c, s[7:0]}.
  function automatic logic [9:0] ref_add(input int w, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    int         sum;
    int         mask;
    logic [7:0] s;
    logic       c;
    logic       v;
    sum  = int'(a) + int'(b) + int'(cin);
    mask = (1 << w) - 1;
    s    = 8'(sum & mask);
    c    = ((sum >> w) & 1) != 0;
    v    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {v, c, s};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb();
    chk("w1_comb", {ovf1, c_out1, 7'b0, s_out1}, ref_add(1, {7'b0, a1}, {7'b0, b1}, cin1));
    chk("w4_comb", {ovf4, c_out4, 4'b0, s_out4}, ref_add(4, {4'b0, a4}, {4'b0, b4}, cin4));
    chk("w8_comb", {ovf8, c_out8, s_out8},       ref_add(8, a8, b8, cin8));
  endtask

  task automatic check_reg();
    chk("w1_reg", {ovf_reg1, c_reg1, 7'b0, s_reg1}, e_reg1);
    chk("w4_reg", {ovf_reg4, c_reg4, 4'b0, s_reg4}, e_reg4);
    chk("w8_reg", {ovf_reg8, c_reg8, s_reg8},       e_reg8);
  endtask

  // Record what the next rising edge should capture, then advance past that
  // edge. An asserted reset makes the expected captured values zero.
  task automatic tick();
    if (rst) begin
      e_reg1 = '0; e_reg4 = '0; e_reg8 = '0;
    end else begin
      e_reg1 = ref_add(1, {7'b0, a1}, {7'b0, b1}, cin1);
      e_reg4 = ref_add(4, {4'b0, a4}, {4'b0, b4}, cin4);
      e_reg8 = ref_add(8, a8, b8, cin8);
    end
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt [8];
  logic [2:0] combo;

  initial begin
    // Truth table entries, indexed by {c_in,a,b}, with each entry {s,c}.
    tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    e_reg1 = '0; e_reg4 = '0; e_reg8 = '0;

    rst = 1'b1;
    a1 = 0; b1 = 0; cin1 = 0;
    a4 = 0; b4 = 0; cin4 = 0;
    a8 = 0; b8 = 0; cin8 = 0;
    #2;
    check_reg();

    // Exhaustive WIDTH=1 truth table. Each combination is held for 10 time units.
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      {cin1, a1, b1} = combo;
      #1;
      chk("w1_truth", {8'b0, s_out1, c_out1}, {8'b0, tt[i]});
      check_comb();
      #9;
    end

    // WIDTH=4 wrap-around case and overflow case. These run while reset is
    // held, so the combinational path must still track the inputs.
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    #1;
    chk("w4_wrap", {ovf4, c_out4, 4'b0, s_out4}, {1'b0, 1'b1, 8'h00});
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
    #1;
    chk("w4_ovf", {ovf4, c_out4, 4'b0, s_out4}, {1'b1, 1'b0, 8'h08});
    check_reg();

    // Release reset and load a known nonzero value.
    @(negedge clk);
    rst = 1'b0;
    a4 = 4'h5; b4 = 4'h1; cin4 = 1'b0;
    tick();
    chk("w4_preload", {ovf_reg4, c_reg4, 4'b0, s_reg4}, {2'b00, 8'h06});

    // Present 3+4+1. The register keeps the old value until the next edge.
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h4; cin4 = 1'b1;
    #1;
    chk("w4_before_edge", {ovf_reg4, c_reg4, 4'b0, s_reg4}, {2'b00, 8'h06});
    tick();
    chk("w4_after_edge", {ovf_reg4, c_reg4, 4'b0, s_reg4}, {1'b1, 1'b0, 8'h08});
    check_reg();

    // Assert reset asynchronously, between clock edges.
    #2;
    rst = 1'b1;
    #1;
    chk("w4_async_rst", {ovf_reg4, c_reg4, 4'b0, s_reg4}, 10'h000);
    chk("w4_comb_in_rst", {6'b0, s_out4}, 10'h008);
    e_reg1 = '0; e_reg4 = '0; e_reg8 = '0;
    check_reg();
    tick();
    check_reg();

    // The first edge after reset is released captures the current sum.
    @(negedge clk);
    rst = 1'b0;
    a4 = 4'hA; b4 = 4'h6; cin4 = 1'b0;
    tick();
    chk("w4_post_rst", {ovf_reg4, c_reg4, 4'b0, s_reg4}, {1'b0, 1'b1, 8'h00});
    check_reg();

    // Randomized regression across all three widths.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      #1;
      check_comb();
      tick();
      check_reg();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/full_add.md
Name: full_add

Overview:
- Binary full adder: sums operands a, b and carry-in c_in; produces sum and carry-out.
- Default WIDTH=1 is the classic single-bit full adder cell.
- Larger WIDTH builds a ripple-carry adder from chained 1-bit cells.
- Sits in the datapath as an arithmetic primitive. It provides combinational results plus a registered copy for pipelined consumers.

Parameters:
- WIDTH, 1, operand/sum bit width (must be >= 1).

Ports:
- clk  input  1  clock; used only by the registered outputs.
- rst  input  1  asynchronous, active-high reset; clears registered outputs only.
- c_in  input  1  carry-in to bit 0.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s_out  output  WIDTH  combinational sum, (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  combinational carry-out of the MSB.
- ovf  output  1  combinational two's-complement overflow.
- s_reg  output  WIDTH  s_out registered on rising clk.
- c_reg  output  1  c_out registered on rising clk.
- ovf_reg  output  1  ovf registered on rising clk.

Behaviour:
- Combinational path, with zero cycle latency and no dependence on clk or rst:
  - {c_out, s_out} = a + b + c_in, computed at WIDTH+1 bits, with no truncation before the carry is taken.
  - Per bit i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])); c[0] = c_in; c_out = c[WIDTH].
  - ovf = c[WIDTH] ^ c[WIDTH-1]. For WIDTH=1, c[0] is c_in.
  - Outputs settle within one propagation delay of any input change. There are no latches and no state.
- WIDTH=1 truth table (c_in,a,b -> s_out,c_out):
  - 000->00, 001->10, 010->10, 011->01
  - 100->10, 101->01, 110->01, 111->11
- Wrap-around: an all-ones operand plus carry gives s_out=0, c_out=1.
- Registered path:
  - On rising clk with rst=0: s_reg<=s_out, c_reg<=c_out, ovf_reg<=ovf.
  - One-cycle latency from inputs that are stable at the clock edge.
- Reset:
  - rst=1 immediately forces s_reg=0, c_reg=0, ovf_reg=0, independent of clk.
  - These values hold while rst is high.
  - The first rising clk after rst deasserts captures the current sum.
  - Reset mid-operation discards the pending registered result. Combinational outputs keep tracking their inputs throughout reset.
- X inputs propagate per normal operator semantics. No special handling.

Decomposition:
- Sub-module full_add_cell: 1-bit a, b, c_in -> s, c_out, combinational gates only.
- full_add instantiates WIDTH cells in a generate loop, chaining carries, and adds the overflow logic and output registers.
- Shared package: none required. The default width constant FULL_ADD_WIDTH_DEFAULT=1 may live in the team's arithmetic package if one exists.

Test Plan:
- WIDTH=1, apply all 8 (c_in,a,b) combinations, each held 10 time units -> s_out/c_out match the truth table above (e.g. 1,1,1 -> s=1, c=1).
- WIDTH=4, a=4'hF, b=4'h0, c_in=1 -> s_out=4'h0, c_out=1, ovf=0. Then a=4'h7, b=4'h1, c_in=0 -> s_out=4'h8, c_out=0, ovf=1.
- WIDTH=4 registered path:
  - rst low, a=4'h3, b=4'h4, c_in=1, one rising clk -> s_reg=4'h8, c_reg=0, ovf_reg=1.
  - Before that edge, s_reg still holds its previous value.
- Assert rst asynchronously between clock edges while s_reg is nonzero -> s_reg/c_reg/ovf_reg go to 0 immediately, and s_out keeps showing the current sum.
- Deassert rst with a=4'hA, b=4'h6, c_in=0 -> next rising clk gives s_reg=4'h0, c_reg=1, ovf_reg=0.
- Random regression, WIDTH in {1,4,8}, 1000 vectors -> {c_out,s_out} equals the reference sum a+b+c_in, and the registered outputs equal the prior-cycle combinational values.
